// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: UART-side, ALU-side and TX-side signals of the command sequencer
interface alu_cmd_sequencer_if #(
  parameter int N_DATA       = 8,
  parameter int NB_OPERATION = 6
);
  logic [N_DATA-1:0]       rx_data;
  logic                    rx_valid;
  logic [N_DATA-1:0]       alu_result;
  logic                    tx_done;
  logic [N_DATA-1:0]       alu_data_a;
  logic [N_DATA-1:0]       alu_data_b;
  logic [NB_OPERATION-1:0] alu_data_op;
  logic [N_DATA-1:0]       tx_data;
  logic                    tx_start;
  logic                    busy;
  logic                    overrun;
  logic                    frame_err;
  modport master (
    output rx_data, rx_valid, alu_result, tx_done,
    input  alu_data_a, alu_data_b, alu_data_op, tx_data, tx_start, busy, overrun, frame_err
  );
  modport slave (
    input  rx_data, rx_valid, alu_result, tx_done,
    output alu_data_a, alu_data_b, alu_data_op, tx_data, tx_start, busy, overrun, frame_err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects A,B,OP frames, settles the ALU, captures and sends the result.
// Define ALU_SEQ_TIMEOUT_EN to abort half-received frames after TIMEOUT_CYCLES idle cycles.
module alu_cmd_sequencer #(
  parameter int N_DATA         = 8,
  parameter int NB_OPERATION   = 6,
  parameter int ALU_LATENCY    = 1,
  parameter int NB_TIMEOUT     = 16,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic               i_clk,
  input logic               i_rst,
  alu_cmd_sequencer_if.slave sif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_B   = 3'd1;
  localparam logic [2:0] GET_OP  = 3'd2;
  localparam logic [2:0] EXEC    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] WAIT_TX = 3'd5;
  localparam int NB_LAT = ALU_LATENCY > 1 ? $clog2(ALU_LATENCY) : 1;
  logic [2:0]              state_q, state_d;
  logic [NB_LAT-1:0]       lat_q, lat_d;
  logic [N_DATA-1:0]       a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OPERATION-1:0] op_q, op_d;
  logic                    ovr_q, ovr_d, ferr_q, ferr_d;
  logic                    collecting, expired;
  assign collecting = state_q == GET_B || state_q == GET_OP;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] idle_q, idle_d;
  assign expired = idle_q == NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
  // An accepted byte or an abort both restart the count from zero
  always_comb idle_d = (collecting && !sif.rx_valid && !expired) ? idle_q + 1'b1 : '0;
  always_ff @(posedge i_clk) idle_q <= i_rst ? '0 : idle_d;
`else
  localparam int unused_timeout = NB_TIMEOUT + TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    ovr_d   = sif.rx_valid && (state_q == EXEC || state_q == SEND || state_q == WAIT_TX);
    ferr_d  = collecting && !sif.rx_valid && expired;
    case (state_q)
      IDLE: if (sif.rx_valid) begin
        a_d     = sif.rx_data;
        state_d = GET_B;
      end
      GET_B: if (sif.rx_valid) begin
        b_d     = sif.rx_data;
        state_d = GET_OP;
      end else if (expired) state_d = IDLE;
      GET_OP: if (sif.rx_valid) begin
        op_d    = sif.rx_data[NB_OPERATION-1:0];
        lat_d   = '0;
        state_d = EXEC;
      end else if (expired) state_d = IDLE;
      EXEC: if (lat_q == NB_LAT'(ALU_LATENCY - 1)) begin
        tx_d    = sif.alu_result;
        state_d = SEND;
      end else lat_d = lat_q + 1'b1;
      SEND:    state_d = WAIT_TX;
      WAIT_TX: state_d = sif.tx_done ? IDLE : WAIT_TX;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end
  assign sif.alu_data_a  = a_q;
  assign sif.alu_data_b  = b_q;
  assign sif.alu_data_op = op_q;
  assign sif.tx_data     = tx_q;
  assign sif.tx_start    = state_q == SEND;
  assign sif.busy        = state_q != IDLE;
  assign sif.overrun     = ovr_q;
  assign sif.frame_err   = ferr_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed scenarios plus random traffic against a frame-level reference model
module tb_alu_cmd_sequencer;
  localparam int L  = 1;
  localparam int TO = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer_if #(.N_DATA(8), .NB_OPERATION(6)) sif();
  alu_cmd_sequencer #(
    .N_DATA(8), .NB_OPERATION(6), .ALU_LATENCY(L), .NB_TIMEOUT(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .sif(sif)
  );
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b[2:0]);
      6'h02:   return a >> b[2:0];
      default: return a ^ 8'h5a;
    endcase
  endfunction
  assign sif.alu_result = alu(sif.alu_data_a, sif.alu_data_b, sif.alu_data_op);
  // Reference model: mode 0 collecting (got = bytes held), 1 settling, 2 sending, 3 awaiting tx_done
  int mode = 0, got = 0, left = 0, idle = 0;
  logic [7:0] ea = '0, eb = '0, etx = '0;
  logic [5:0] eop = '0;
  bit ovr = 0, ferr = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask
  task automatic step(input bit r, input bit v, input logic [7:0] d, input bit done);
    rst = r;
    sif.rx_valid = v;
    sif.rx_data = d;
    sif.tx_done = done;
    @(posedge clk);
    if (r) begin
      mode = 0; got = 0; left = 0; idle = 0;
      ea = '0; eb = '0; eop = '0; etx = '0; ovr = 0; ferr = 0;
    end else begin
      ovr = v && mode != 0;
      ferr = 0;
      case (mode)
        0: if (v) begin
          if (got == 0) ea = d;
          else if (got == 1) eb = d;
          else eop = d[5:0];
          idle = 0;
          if (got == 2) begin got = 0; mode = 1; left = L; end
          else got++;
        end else if (got != 0) begin
`ifdef ALU_SEQ_TIMEOUT_EN
          idle++;
          if (idle == TO) begin got = 0; idle = 0; ferr = 1; end
`endif
        end
        1: begin
          left--;
          if (left == 0) begin etx = alu(ea, eb, eop); mode = 2; end
        end
        2: mode = 3;
        default: if (done) mode = 0;
      endcase
    end
    #1;
    chk("alu_a", sif.alu_data_a, ea);
    chk("alu_b", sif.alu_data_b, eb);
    chk("alu_op", sif.alu_data_op, eop);
    chk("tx_data", sif.tx_data, etx);
    chk("tx_start", sif.tx_start, mode == 2);
    chk("busy", sif.busy, mode != 0 || got != 0);
    chk("overrun", sif.overrun, ovr);
    chk("frame_err", sif.frame_err, ferr);
  endtask
  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    step(0, 1, a, 0);
    step(0, 1, b, 0);
    step(0, 1, op, 0);
  endtask
  initial begin
    sif.rx_valid = 0;
    sif.rx_data = '0;
    sif.tx_done = 0;
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h77, 1);
    frame(8'h05, 8'h03, 8'h20);
    idle_n(3);
    step(0, 0, 8'h00, 1);
    idle_n(2);
    chk("t1_result", sif.tx_data, 8'h08);
    frame(8'h40, 8'h0f, 8'h22);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h11, 0);
    idle_n(1);
    step(0, 0, 8'h00, 1);
    frame(8'h0c, 8'h0a, 8'h24);
    idle_n(3);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'hAA, 0);
    idle_n(TO);
    step(0, 1, 8'h01, 0);
    idle_n(TO - 1);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h26, 0);
    idle_n(3);
    step(0, 0, 8'h00, 1);
    frame(8'h99, 8'h01, 8'h25);
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    frame(8'h80, 8'h02, 8'h03);
    idle_n(3);
    step(1, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    frame(8'h81, 8'h02, 8'hE2);
    chk("op_trunc", sif.alu_data_op, 6'h22);
    idle_n(2);
    step(0, 0, 8'h00, 1);
    frame(8'h33, 8'h44, 8'h26);
    idle_n(2);
    step(0, 0, 8'h00, 1);
    for (int i = 0; i < 5000; i++)
      step($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 3) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
